// File: rtl/parity_serial_tx.sv
// Frames a parallel word onto a serial line: start bit, data LSB first,
// parity bit, stop bit. The line idles high.
module parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_W-1:0] word, input logic odd);
    parity_of = odd ? ~^word : ^word;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              parity_r, parity_s;
  logic              tx_bit_r, tx_bit_s;
  logic              tx_active_r, tx_active_s;
  logic              tx_done_r, tx_done_s;
  logic              period_end_s;

  // State, datapath and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      parity_r    <= 1'b0;
      tx_bit_r    <= 1'b1;
      tx_active_r <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      parity_r    <= parity_s;
      tx_bit_r    <= tx_bit_s;
      tx_active_r <= tx_active_s;
      tx_done_r   <= tx_done_s;
    end
  end

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    bit_cnt_s    = bit_cnt_r;
    shift_s      = shift_r;
    parity_s     = parity_r;
    tx_bit_s     = 1'b1;
    period_end_s = (cnt_r == CNT_LAST);

    // The cycle counter only runs inside a frame and wraps at each bit period.
    if (state_r == ST_IDLE) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (period_end_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s  = ST_START;
          shift_s  = in_data;
          parity_s = parity_of(in_data, PARITY_ODD != 0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (period_end_s) begin
          state_s   = ST_DATA;
          bit_cnt_s = {BIT_W{1'b0}};
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (!period_end_s) begin
          state_s = ST_DATA;
        end else if (bit_cnt_r == BIT_LAST) begin
          state_s = ST_PARITY;
        end else begin
          state_s   = ST_DATA;
          bit_cnt_s = bit_cnt_r + BIT_W'(1);
          shift_s   = shift_r >> 1;
        end
      end
      ST_PARITY: begin
        if (period_end_s) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (period_end_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they land in the same cycle as the state.
    case (state_s)
      ST_IDLE:   tx_bit_s = 1'b1;
      ST_START:  tx_bit_s = 1'b0;
      ST_DATA:   tx_bit_s = shift_s[0];
      ST_PARITY: tx_bit_s = parity_s;
      ST_STOP:   tx_bit_s = 1'b1;
      default:   tx_bit_s = 1'b1;
    endcase

    tx_active_s = (state_s != ST_IDLE);
    tx_done_s   = (state_r == ST_STOP) && (state_s == ST_IDLE);
  end

  assign in_ready  = rst_n && (state_r == ST_IDLE);
  assign tx_bit    = tx_bit_r;
  assign tx_active = tx_active_r;
  assign tx_done   = tx_done_r;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed + random checks of parity_serial_tx against a frame-level model
// for three configurations: (4 clk/bit, even), (4 clk/bit, odd), (1 clk/bit, even).
module tb_parity_serial_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [2:0] tx_bit;
  logic [2:0] tx_active;
  logic [2:0] tx_done;

  int total;
  int bad;

  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_even4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data),
    .in_ready(in_ready[0]), .tx_bit(tx_bit[0]), .tx_active(tx_active[0]), .tx_done(tx_done[0]));

  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data),
    .in_ready(in_ready[1]), .tx_bit(tx_bit[1]), .tx_active(tx_active[1]), .tx_done(tx_done[1]));

  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u_even1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_data(in_data),
    .in_ready(in_ready[2]), .tx_bit(tx_bit[2]), .tx_active(tx_active[2]), .tx_done(tx_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit k of a word: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
  function automatic logic model_bit(input logic [7:0] d, input logic odd, input int k);
    int ones;
    ones = $countones(d);
    if (k == 0) return 1'b0;
    if (k <= 8) return ((int'(d) >> (k - 1)) % 2) == 1;
    if (k == 9) return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    return 1'b1;
  endfunction

  function automatic logic [3:0] obs(input int u);
    return {tx_bit[u], tx_active[u], in_ready[u], tx_done[u]};
  endfunction

  function automatic int cpb_of(input int u);
    return (u == 2) ? 1 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed{bit,act,rdy,done}=%b expected=%b", tag, o, e);
    end
  endtask

  // Checks every cycle of a frame starting at its first cycle; returns on the done cycle.
  task automatic expect_frame(input int u, input logic odd, input logic [7:0] d, input string tag);
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < cpb_of(u); c++) begin
        chk($sformatf("%s_u%0d_d%02h_b%0d", tag, u, d, k), obs(u), {model_bit(d, odd, k), 3'b100});
        tick();
      end
    end
  endtask

  task automatic send(input int u, input logic [7:0] d, input string tag);
    chk({tag, "_ready"}, obs(u), 4'b1010);
    in_data     = d;
    in_valid[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
    expect_frame(u, u == 1, d, tag);
    chk({tag, "_done"}, obs(u), 4'b1011);
    tick();
    chk({tag, "_after"}, obs(u), 4'b1010);
  endtask

  initial begin
    logic [7:0] rd;
    int         ru;
    int         gap;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 3'b000;
    in_data  = 8'h00;

    // Reset state, with a producer pushing while reset is held.
    tick();
    in_valid = 3'b111;
    in_data  = 8'h5A;
    for (int u = 0; u < 3; u++) chk($sformatf("reset_u%0d", u), obs(u), 4'b1000);
    tick();
    for (int u = 0; u < 3; u++) chk($sformatf("reset_accept_u%0d", u), obs(u), 4'b1000);
    in_valid = 3'b000;
    rst_n    = 1'b1;
    tick();

    // Idle hold.
    for (int n = 0; n < 20; n++) begin
      for (int u = 0; u < 3; u++) chk($sformatf("idle_u%0d_c%0d", u, n), obs(u), 4'b1010);
      tick();
    end

    // Directed frames and parity corners.
    send(0, 8'hA5, "frame_a5");
    send(0, 8'h07, "even_07");
    send(1, 8'h00, "odd_00");
    send(1, 8'hFF, "odd_ff");

    // Back-to-back with in_valid held and in_data changing mid-frame.
    chk("b2b_ready", obs(2), 4'b1010);
    in_data     = 8'h3C;
    in_valid[2] = 1'b1;
    tick();
    in_data = 8'hC3;
    expect_frame(2, 1'b0, 8'h3C, "b2b_a");
    chk("b2b_gap", obs(2), 4'b1011);
    tick();
    in_valid[2] = 1'b0;
    expect_frame(2, 1'b0, 8'hC3, "b2b_b");
    chk("b2b_done", obs(2), 4'b1011);
    tick();
    chk("b2b_after", obs(2), 4'b1010);

    // Reset during data bit 3 (cycles 17..20 of the frame).
    in_data     = 8'h52;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int n = 1; n < 18; n++) begin
      chk($sformatf("abort_c%0d", n), obs(0), {model_bit(8'h52, 1'b0, (n - 1) / 4), 3'b100});
      tick();
    end
    chk("abort_bit3", obs(0), 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async", obs(0), 4'b1000);
    tick();
    chk("abort_held", obs(0), 4'b1000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_release", obs(0), 4'b1010);
    tick();
    chk("abort_no_done", obs(0), 4'b1010);
    send(0, 8'h81, "post_rst");

    // Random words on random instances with random idle gaps.
    for (int i = 0; i < 9; i++) begin
      ru  = int'($urandom_range(0, 2));
      rd  = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        chk($sformatf("rnd_gap_u%0d", ru), obs(ru), 4'b1010);
        tick();
      end
      send(ru, rd, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
